// File: rtl/mem_access_sequencer.sv
// MAR/MDR memory access sequencer: turns a valid/ready word request into ordered memory strobes.
// Optional write read-back check is enabled by defining MEM_SEQ_WRITE_VERIFY_EN.
module mem_access_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic [DATA_W-1:0] Buss,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              ldMAR,
  output logic              ldMDR,
  output logic              selMDR,
  output logic              memWE,
  output logic              enaMDR
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LDMAR  = 4'd1,
    S_RD_MDR = 4'd2,
    S_RD_BUS = 4'd3,
    S_WR_MDR = 4'd4,
    S_WR_WE  = 4'd5,
`ifdef MEM_SEQ_WRITE_VERIFY_EN
    S_VF_MDR = 4'd6,
    S_VF_BUS = 4'd7,
`endif
    S_RSP    = 4'd8
  } state_t;

  state_t              r_state;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_bus_out;
  logic                r_bus_oe, r_ldMAR, r_ldMDR, r_selMDR, r_memWE, r_enaMDR;
  logic [DATA_W-1:0]   w_addr_ext;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
  logic                r_rsp_err;
`endif

  assign w_addr_ext = {{(DATA_W-ADDR_W){1'b0}}, req_addr};

  // Outputs are registered alongside the state so each strobe lines up with the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_bus_out   <= '0;
      r_bus_oe    <= 1'b0;
      r_ldMAR     <= 1'b0;
      r_ldMDR     <= 1'b0;
      r_selMDR    <= 1'b0;
      r_memWE     <= 1'b0;
      r_enaMDR    <= 1'b0;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_bus_out <= '0;
      r_bus_oe  <= 1'b0;
      r_ldMAR   <= 1'b0;
      r_ldMDR   <= 1'b0;
      r_selMDR  <= 1'b0;
      r_memWE   <= 1'b0;
      r_enaMDR  <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_write   <= req_write;
          r_wdata   <= req_wdata;
          r_bus_out <= w_addr_ext;
          r_bus_oe  <= 1'b1;
          r_ldMAR   <= 1'b1;
          r_state   <= S_LDMAR;
        end
        S_LDMAR: if (r_write) begin
          r_bus_out <= r_wdata;
          r_bus_oe  <= 1'b1;
          r_ldMDR   <= 1'b1;
          r_state   <= S_WR_MDR;
        end else begin
          r_ldMDR   <= 1'b1;
          r_selMDR  <= 1'b1;
          r_state   <= S_RD_MDR;
        end
        S_RD_MDR: begin
          r_enaMDR <= 1'b1;
          r_state  <= S_RD_BUS;
        end
        S_RD_BUS: begin
          r_rsp_data  <= Buss;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
        end
        S_WR_MDR: begin
          r_memWE <= 1'b1;
          r_state <= S_WR_WE;
        end
        S_WR_WE: begin
          r_rsp_data <= r_wdata;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
          r_ldMDR    <= 1'b1;
          r_selMDR   <= 1'b1;
          r_state    <= S_VF_MDR;
`else
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
`endif
        end
`ifdef MEM_SEQ_WRITE_VERIFY_EN
        S_VF_MDR: begin
          r_enaMDR <= 1'b1;
          r_state  <= S_VF_BUS;
        end
        S_VF_BUS: begin
          r_rsp_data  <= Buss;
          r_rsp_err   <= (Buss != r_wdata);
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
        end
`endif
        S_RSP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
          r_rsp_err   <= 1'b0;
`endif
          r_state     <= S_IDLE;
        end
        default: begin
          r_rsp_valid <= 1'b0;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
          r_rsp_err   <= 1'b0;
`endif
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif
  assign bus_out   = r_bus_out;
  assign bus_oe    = r_bus_oe;
  assign ldMAR     = r_ldMAR;
  assign ldMDR     = r_ldMDR;
  assign selMDR    = r_selMDR;
  assign memWE     = r_memWE;
  assign enaMDR    = r_enaMDR;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a small MAR/MDR memory model on the bus.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;
  logic [15:0] w_buss, bus_out;
  logic        bus_oe, ldMAR, ldMDR, selMDR, memWE, enaMDR;
  logic        r_force0 = 1'b0;

  logic [15:0] mem [256];
  logic [7:0]  mar;
  logic [15:0] mdr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign w_buss = r_force0 ? 16'h0000 : bus_oe ? bus_out : enaMDR ? mdr : 16'h0000;

  always @(posedge clk) begin
    if (ldMAR) mar <= w_buss[7:0];
    if (ldMDR) mdr <= selMDR ? mem[mar] : w_buss;
    if (memWE) mem[mar] <= mdr;
  end

  mem_access_sequencer #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .Buss(w_buss), .bus_out(bus_out), .bus_oe(bus_oe),
    .ldMAR(ldMAR), .ldMDR(ldMDR), .selMDR(selMDR), .memWE(memWE), .enaMDR(enaMDR)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // strobe vector: {ldMAR, bus_oe, ldMDR, selMDR, memWE, enaMDR}
  function automatic logic [31:0] strb();
    return {26'd0, ldMAR, bus_oe, ldMDR, selMDR, memWE, enaMDR};
  endfunction

  task automatic do_store(input logic [7:0] a, input logic [15:0] d, input bit frc);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    step;
    req_valid = 1'b0;
    chk("st_ldmar_bus", bus_out, {16'h0, 8'h00, a});
    chk("st_ldmar_strb", strb(), 6'b110000);
    chk("st_busy", req_ready, 0);
    step;
    chk("st_wrmdr_bus", bus_out, d);
    chk("st_wrmdr_strb", strb(), 6'b011000);
    step;
    chk("st_we_strb", strb(), 6'b000010);
    chk("st_we_novalid", rsp_valid, 0);
`ifdef MEM_SEQ_WRITE_VERIFY_EN
    step;
    chk("st_vfmdr_strb", strb(), 6'b001100);
    step;
    chk("st_vfbus_strb", strb(), 6'b000001);
    r_force0 = frc;
    step;
    r_force0 = 1'b0;
    chk("st_rsp_valid", rsp_valid, 1);
    chk("st_rsp_data", rsp_data, frc ? 16'h0000 : d);
    chk("st_rsp_err", rsp_err, {31'd0, frc});
`else
    step;
    chk("st_rsp_valid", rsp_valid, 1);
    chk("st_rsp_data", rsp_data, d);
    chk("st_rsp_err", rsp_err, 0);
`endif
    chk("st_rsp_strb", strb(), 0);
    step;
    chk("st_idle_ready", req_ready, 1);
    chk("st_idle_novalid", rsp_valid, 0);
  endtask

  task automatic do_load(input logic [7:0] a, input logic [15:0] exp, input int hold);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = 16'hDEAD;
    step;
    req_valid = 1'b0;
    chk("ld_ldmar_bus", bus_out, {16'h0, 8'h00, a});
    chk("ld_ldmar_strb", strb(), 6'b110000);
    step;
    chk("ld_rdmdr_strb", strb(), 6'b001100);
    step;
    chk("ld_rdbus_strb", strb(), 6'b000001);
    chk("ld_rdbus_valid", rsp_valid, 0);
    step;
    chk("ld_rsp_valid", rsp_valid, 1);
    chk("ld_rsp_data", rsp_data, exp);
    if (hold > 0) begin
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        step;
        chk("ld_hold_valid", rsp_valid, 1);
        chk("ld_hold_data", rsp_data, exp);
        chk("ld_hold_busy", req_ready, 0);
      end
      rsp_ready = 1'b1;
    end
    step;
    chk("ld_idle_ready", req_ready, 1);
    chk("ld_idle_novalid", rsp_valid, 0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    chk("rst_ready", req_ready, 1);
    chk("rst_strb", strb(), 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_busout", bus_out, 0);

    do_store(8'h12, 16'hBEEF, 1'b0);
    do_load(8'h12, 16'hBEEF, 5);
    do_store(8'hFF, 16'h1234, 1'b0);
    do_load(8'hFF, 16'h1234, 0);
    do_load(8'h12, 16'hBEEF, 0);

    // abandon a load mid-access
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h12;
    step;
    req_valid = 1'b0;
    step;
    chk("mid_rdmdr_strb", strb(), 6'b001100);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_strb", strb(), 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_ready", req_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("mid_no_rsp", rsp_valid, 0);
    end
    do_load(8'h12, 16'hBEEF, 0);

`ifdef MEM_SEQ_WRITE_VERIFY_EN
    do_store(8'h00, 16'h5A5A, 1'b0);
    do_store(8'h00, 16'h5A5A, 1'b1);
    do_load(8'h00, 16'h5A5A, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
